aes256_enc_sched: RTL and testbench
===================================

# aes256_enc_sched

Round-robin scheduler that shares one `AES256_enc` core among `NREQ` requesters. It arbitrates the requests, then drives the core's control-register write (`addr=0`) and its data load (`addr=1`). It waits the core's fixed encryption latency, then returns the ciphertext with the requester ID on a valid/ready response channel. It sits directly in front of `AES256_enc` and is the only block that drives the core's `plaintext`, `addr` and `flags` inputs.

## Interface
- `NREQ`, 4: number of requesters; must be at least 2.
- `CORE_LAT`, 60: core latency in cycles, counted from the data-load cycle (`addr=1`) to the first cycle `encData` is valid; must be at least 1.
- `NFLAGS`, 8: width of the core `flags` input.
- `CTRL_WORD`, 128'h1: value written to the core control register.
- `IDW`, `$clog2(NREQ)`: width of `resp_id` (localparam).

- `clk`  in  1  single clock; all logic is on the rising edge.
- `resetn`  in  1  reset; synchronous, active-high (asserted = 1).
- `req_valid`  in  NREQ  per-requester request.
- `req_ready`  out  NREQ  one-hot grant/accept strobe.
- `req_data`  in  NREQ×128  plaintext per requester; packed, requester i at `[i*128 +: 128]`.
- `req_flags`  in  NREQ×NFLAGS  flags per requester; packed the same way.
- `resp_valid`  out  1  ciphertext available.
- `resp_ready`  in  1  response consumer ready.
- `resp_id`  out  IDW  index of the requester that owns `resp_data`.
- `resp_data`  out  128  ciphertext.
- `core_plaintext`  out  128  to core `plaintext`.
- `core_addr`  out  1  to core `addr`; 0 = control register, 1 = data.
- `core_flags`  out  NFLAGS  to core `flags`.
- `core_encData`  in  128  from core `encData`.
- `busy`  out  1  high whenever the state is not IDLE.

## Operation
FSM states: IDLE, CFG, LOAD, WAIT, RESP.
- **IDLE**
  - Core outputs: `core_addr=0`, `core_plaintext=CTRL_WORD`, `core_flags=0`.
  - If any `req_valid` is high, grant `g` = first requester with `req_valid` high, searching from `last+1` modulo `NREQ` (round-robin).
  - `req_ready[g]=1` combinationally in the same cycle; the handshake completes that cycle.
  - Latch `req_data[g]`, `req_flags[g]` and `g`; set `last=g`; go to CFG.
  - A requester may drop `req_valid` before it is granted; nothing is captured for it.
- **CFG** (1 cycle): `core_addr=0`, `core_plaintext=CTRL_WORD`, `core_flags=latched flags`. Go to LOAD.
- **LOAD** (1 cycle): `core_addr=1`, `core_plaintext=latched data`, `core_flags=latched flags`.
  - Load counter with `CORE_LAT-1`; go to WAIT.
- **WAIT**
  - Core outputs hold the LOAD values (`core_addr=1`, latched data and flags).
  - Decrement the counter each cycle.
  - In the cycle where counter = 0: register `core_encData` into `resp_data`, latched ID into `resp_id`; go to RESP.
- **RESP**
  - Core outputs as in IDLE.
  - `resp_valid=1`; `resp_data` and `resp_id` stable.
  - On `resp_valid && resp_ready`, go to IDLE.
- `req_ready` is all-zero in every state except IDLE. At most one request is in flight.
- Counter width is `$clog2(CORE_LAT)+1`, so it never wraps below 0.

## Timing
- Reset values:
  - state IDLE, `last=NREQ-1` (requester 0 has first priority);
  - `req_ready=0`, `resp_valid=0`, `resp_id=0`, `resp_data=0`, `busy=0`;
  - `core_addr=0`, `core_plaintext=CTRL_WORD`, `core_flags=0`.
- Request accepted in cycle T:
  - CFG at T+1, LOAD at T+2;
  - WAIT from T+3 to T+2+CORE_LAT;
  - `resp_valid` rises at T+3+CORE_LAT.
- With `resp_ready` held high, IDLE is at T+4+CORE_LAT, so back-to-back throughput is one request per CORE_LAT+4 cycles.
- A `resp_ready` stall holds RESP indefinitely. `resp_data` and `resp_id` stay stable, and no new grant is made.
- `req_valid` changes while `busy=1` have no effect.
- Reset asserted in any state:
  - next cycle all outputs and `last` are at their reset values;
  - the in-flight request is discarded with no response.
- Reset asserted in the same cycle as an IDLE grant: the grant is void and `req_ready` is forced to 0.

## Test plan
- **Single request.** After reset, `req_valid[2]=1` with data 128'h00000101030307070f0f1f1f3f3f7f7f, flags 8'h01, against the real core (`CORE_LAT=60`) -> `req_ready[2]` pulses at T; `core_addr` is 0 at T+1 and 1 at T+2; `resp_valid` rises at T+63 with `resp_id=2` and `resp_data=128'hcc6f84800354f24a045f32ee85ff2d4b`.
- **Round-robin fairness.** Behavioural core model returning `plaintext ^ 128'hA5…A5` after `CORE_LAT=4`; all four `req_valid` held high; `resp_ready=1` -> grants in order 0,1,2,3,0; grants spaced exactly 8 cycles apart.
- **Response back-pressure.** Same model; `resp_ready=0` for 10 cycles after `resp_valid` rises -> `resp_valid`, `resp_data` and `resp_id` held constant; `req_ready` stays 0; the next grant comes 1 cycle after the `resp_ready` handshake.
- **Reset mid-WAIT.** `resetn=1` for 1 cycle during WAIT -> next cycle `busy=0`, `resp_valid=0`, `core_addr=0`, `core_plaintext=CTRL_WORD`; no response for the aborted request; next grant goes to requester 0.
- **Request withdrawal.** `req_valid[1]` is raised while `busy=1` and dropped before the block returns to IDLE -> requester 1 is never granted, and `resp_id=1` never appears.
- **Minimum latency.** `CORE_LAT=1` -> WAIT lasts exactly 1 cycle; `resp_valid` at T+4; `resp_data` equals `core_encData` from the T+3 cycle.

Source files
------------

// File: rtl/aes256_enc_sched.sv
// aes256_enc_sched: round-robin scheduler sharing one AES256_enc core among NREQ requesters,
// sequencing control write, data load, fixed-latency wait and a valid/ready response.
module aes256_enc_sched #(
  parameter int NREQ = 4,
  parameter int CORE_LAT = 60,
  parameter int NFLAGS = 8,
  parameter logic [127:0] CTRL_WORD = 128'h1,
  localparam int IDW = $clog2(NREQ)
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic [NREQ-1:0]          req_valid,
  output logic [NREQ-1:0]          req_ready,
  input  logic [NREQ*128-1:0]      req_data,
  input  logic [NREQ*NFLAGS-1:0]   req_flags,
  output logic                     resp_valid,
  input  logic                     resp_ready,
  output logic [IDW-1:0]           resp_id,
  output logic [127:0]             resp_data,
  output logic [127:0]             core_plaintext,
  output logic                     core_addr,
  output logic [NFLAGS-1:0]        core_flags,
  input  logic [127:0]             core_encData,
  output logic                     busy
);
  localparam int CW = $clog2(CORE_LAT) + 1;
  typedef enum logic [2:0] {S_IDLE, S_CFG, S_LOAD, S_WAIT, S_RESP} state_t;
  state_t r_state, w_next;
  logic [IDW-1:0] r_last, r_id, w_gnt;
  logic [IDW:0] w_i;
  logic [127:0] r_data, w_data;
  logic [NFLAGS-1:0] r_flags, w_flags;
  logic [CW-1:0] r_cnt;
  logic w_found;
  // search starts just after the last winner so every requester gets a turn
  always_comb begin
    w_found = 1'b0;
    w_gnt = '0;
    w_i = '0;
    for (int k = 1; k <= NREQ; k++) begin
      w_i = (IDW+1)'(r_last) + (IDW+1)'(k);
      w_i = w_i >= (IDW+1)'(NREQ) ? w_i - (IDW+1)'(NREQ) : w_i;
      if (!w_found && req_valid[w_i[IDW-1:0]]) begin
        w_found = 1'b1;
        w_gnt = w_i[IDW-1:0];
      end
    end
  end
  always_comb begin
    w_data = '0;
    w_flags = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (w_gnt == IDW'(i)) begin
        w_data = req_data[i*128 +: 128];
        w_flags = req_flags[i*NFLAGS +: NFLAGS];
      end
    end
  end
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  w_next = w_found ? S_CFG : S_IDLE;
      S_CFG:   w_next = S_LOAD;
      S_LOAD:  w_next = S_WAIT;
      S_WAIT:  w_next = r_cnt == '0 ? S_RESP : S_WAIT;
      S_RESP:  w_next = resp_ready ? S_IDLE : S_RESP;
      default: w_next = S_IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (resetn) begin
      r_state <= S_IDLE;
      r_last <= IDW'(NREQ - 1);
      r_id <= '0;
      r_data <= '0;
      r_flags <= '0;
      r_cnt <= '0;
      resp_id <= '0;
      resp_data <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == S_IDLE && w_found) begin
        r_data <= w_data;
        r_flags <= w_flags;
        r_id <= w_gnt;
        r_last <= w_gnt;
      end
      if (r_state == S_LOAD) r_cnt <= CW'(CORE_LAT - 1);
      else if (r_state == S_WAIT && r_cnt != '0) r_cnt <= r_cnt - 1'b1;
      if (r_state == S_WAIT && r_cnt == '0) begin
        resp_data <= core_encData;
        resp_id <= r_id;
      end
    end
  end
  assign req_ready = (r_state == S_IDLE && w_found && !resetn) ? NREQ'(1) << w_gnt : '0;
  assign core_addr = r_state == S_LOAD || r_state == S_WAIT;
  assign core_plaintext = core_addr ? r_data : CTRL_WORD;
  assign core_flags = (core_addr || r_state == S_CFG) ? r_flags : '0;
  assign resp_valid = r_state == S_RESP;
  assign busy = r_state != S_IDLE;
endmodule

// File: tb/tb_aes256_enc_sched.sv
// tb_aes256_enc_sched: checks the scheduler against behavioural XOR core models (latency 4 and 1)
// with a vector table, directed corner sequences and a randomized timeline model.
module tb_aes256_enc_sched;
  localparam int N = 4;
  localparam int LAT = 4;
  localparam logic [127:0] K = {16{8'hA5}};
  localparam logic [127:0] CWD = 128'h1;
  typedef struct {int id; logic [127:0] d; logic [7:0] f; logic [127:0] exp;} vec_t;
  logic clk = 1'b0, resetn = 1'b1, resp_ready = 1'b0;
  logic [N-1:0] req_valid = '0;
  logic [N*128-1:0] req_data = '0;
  logic [N*8-1:0] req_flags = '0;
  logic [N-1:0] rr0, rr1;
  logic rv0, rv1, ca0, ca1, b0, b1;
  logic [1:0] rid0, rid1;
  logic [127:0] rd0, rd1, pt0, pt1, enc0, enc1, m0 = '0, m1 = '0;
  logic [7:0] cf0, cf1;
  logic p0 = 1'b0, p1 = 1'b0;
  int cyc = 0, ld0 = -100, ld1 = -100;
  int n_chk = 0, n_fail = 0;
  always #5 clk = ~clk;
  aes256_enc_sched #(.NREQ(N), .CORE_LAT(LAT), .NFLAGS(8), .CTRL_WORD(CWD)) u0 (
    .clk(clk), .resetn(resetn), .req_valid(req_valid), .req_ready(rr0), .req_data(req_data),
    .req_flags(req_flags), .resp_valid(rv0), .resp_ready(resp_ready), .resp_id(rid0),
    .resp_data(rd0), .core_plaintext(pt0), .core_addr(ca0), .core_flags(cf0),
    .core_encData(enc0), .busy(b0));
  aes256_enc_sched #(.NREQ(N), .CORE_LAT(1), .NFLAGS(8), .CTRL_WORD(CWD)) u1 (
    .clk(clk), .resetn(resetn), .req_valid(req_valid), .req_ready(rr1), .req_data(req_data),
    .req_flags(req_flags), .resp_valid(rv1), .resp_ready(resp_ready), .resp_id(rid1),
    .resp_data(rd1), .core_plaintext(pt1), .core_addr(ca1), .core_flags(cf1),
    .core_encData(enc1), .busy(b1));
  // core models: ciphertext is valid only from load cycle + latency onward, garbage before
  always @(posedge clk) begin
    cyc <= cyc + 1;
    p0 <= ca0;
    p1 <= ca1;
    if (ca0 && !p0) begin ld0 <= cyc; m0 <= pt0; end
    if (ca1 && !p1) begin ld1 <= cyc; m1 <= pt1; end
  end
  assign enc0 = (cyc >= ld0 + LAT) ? m0 ^ K : ~(m0 ^ K);
  assign enc1 = (cyc >= ld1 + 1) ? m1 ^ K : ~(m1 ^ K);

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset();
    resetn = 1'b1;
    req_valid = '0;
    resp_ready = 1'b0;
    tick();
    tick();
    resetn = 1'b0;
  endtask
  function automatic int rr(input logic [N-1:0] v, input int last);
    for (int k = 1; k <= N; k++) if (v[(last + k) % N]) return (last + k) % N;
    return -1;
  endfunction

  vec_t tbl[4];
  initial begin
    logic [127:0] d, e;
    logic [1:0] id;
    logic [3:0] exp_rr;
    int gc, pt, w, g1, r1, seen, g, ml, mph, mid;
    logic [127:0] md;
    logic [7:0] mf;
    tbl[0] = '{2, 128'h00000101030307070f0f1f1f3f3f7f7f, 8'h01, '0};
    tbl[1] = '{0, {$urandom, $urandom, $urandom, $urandom}, 8'h5a, '0};
    tbl[2] = '{3, {128{1'b1}}, 8'hff, '0};
    tbl[3] = '{1, 128'h0, 8'h80, '0};
    foreach (tbl[i]) tbl[i].exp = tbl[i].d ^ K;
    // reset values, including a grant attempt while reset is held
    tick();
    tick();
    req_valid = 4'hF;
    #1;
    chk("rst_ready", rr0, 0);
    chk("rst_rvalid", rv0, 0);
    chk("rst_rid", rid0, 0);
    chk("rst_rdata", rd0, 0);
    chk("rst_busy", b0, 0);
    chk("rst_addr", ca0, 0);
    chk("rst_pt", pt0, CWD);
    chk("rst_flags", cf0, 0);
    tick();
    chk("rst_grant_void", b0, 0);
    do_reset();
    // vector table: one requester at a time, full timeline
    foreach (tbl[i]) begin
      req_data[tbl[i].id*128 +: 128] = tbl[i].d;
      req_flags[tbl[i].id*8 +: 8] = tbl[i].f;
      req_valid = 4'b1 << tbl[i].id;
      resp_ready = 1'b1;
      #1;
      chk("tbl_ready", rr0, 4'b1 << tbl[i].id);
      tick();
      req_valid = '0;
      #1;
      chk("tbl_cfg_addr", ca0, 0);
      chk("tbl_cfg_pt", pt0, CWD);
      chk("tbl_cfg_flags", cf0, tbl[i].f);
      tick();
      #1;
      chk("tbl_load_addr", ca0, 1);
      chk("tbl_load_pt", pt0, tbl[i].d);
      repeat (LAT) tick();
      #1;
      chk("tbl_not_yet", rv0, 0);
      tick();
      #1;
      chk("tbl_rvalid", rv0, 1);
      chk("tbl_rdata", rd0, tbl[i].exp);
      chk("tbl_rid", rid0, tbl[i].id);
      tick();
      #1;
      chk("tbl_idle", b0, 0);
    end
    // round-robin fairness with all requesters active
    do_reset();
    resp_ready = 1'b1;
    req_valid = 4'hF;
    gc = 0;
    pt = 0;
    for (int c = 0; c < 40; c++) begin
      #1;
      if (rr0 != 0) begin
        chk("rr_order", rr0, 4'b1 << (gc % 4));
        if (gc > 0) chk("rr_spacing", c - pt, LAT + 4);
        pt = c;
        gc++;
      end
      tick();
    end
    chk("rr_count", gc, 5);
    // response back-pressure
    do_reset();
    req_data[0 +: 128] = {$urandom, $urandom, $urandom, $urandom};
    req_valid = 4'b0011;
    w = 0;
    #1;
    while (!rv0 && w < 30) begin
      tick();
      #1;
      w++;
    end
    chk("bp_latency", w, LAT + 3);
    chk("bp_rid", rid0, 0);
    chk("bp_rdata", rd0, req_data[0 +: 128] ^ K);
    d = rd0;
    id = rid0;
    for (int c = 0; c < 10; c++) begin
      tick();
      #1;
      chk("bp_hold_valid", rv0, 1);
      chk("bp_hold_data", rd0, d);
      chk("bp_hold_id", rid0, id);
      chk("bp_no_grant", rr0, 0);
    end
    resp_ready = 1'b1;
    tick();
    #1;
    chk("bp_next_grant", rr0, 4'b0010);
    // reset in the middle of WAIT
    do_reset();
    resp_ready = 1'b1;
    req_valid = 4'b0100;
    #1;
    chk("mid_grant", rr0, 4'b0100);
    tick();
    req_valid = '0;
    repeat (3) tick();
    resetn = 1'b1;
    tick();
    resetn = 1'b0;
    #1;
    chk("mid_busy", b0, 0);
    chk("mid_rvalid", rv0, 0);
    chk("mid_addr", ca0, 0);
    chk("mid_pt", pt0, CWD);
    seen = 0;
    for (int c = 0; c < 12; c++) begin
      tick();
      #1;
      if (rv0) seen++;
    end
    chk("mid_no_resp", seen, 0);
    req_valid = 4'hF;
    #1;
    chk("mid_next_grant", rr0, 4'b0001);
    // request withdrawal while busy
    do_reset();
    resp_ready = 1'b1;
    req_valid = 4'b0001;
    #1;
    chk("wd_grant", rr0, 4'b0001);
    tick();
    req_valid = 4'b0010;
    for (int c = 0; c < 3; c++) begin
      #1;
      chk("wd_busy_no_grant", rr0, 0);
      tick();
    end
    req_valid = '0;
    g1 = 0;
    r1 = 0;
    for (int c = 0; c < 20; c++) begin
      #1;
      if (rr0[1]) g1++;
      if (rv0 && rid0 == 2'd1) r1++;
      tick();
    end
    chk("wd_never_granted", g1, 0);
    chk("wd_never_resp", r1, 0);
    // minimum latency instance
    do_reset();
    resp_ready = 1'b1;
    req_data[3*128 +: 128] = {$urandom, $urandom, $urandom, $urandom};
    req_valid = 4'b1000;
    #1;
    chk("min_grant", rr1, 4'b1000);
    tick();
    req_valid = '0;
    #1;
    chk("min_cfg", ca1, 0);
    tick();
    #1;
    chk("min_load", ca1, 1);
    tick();
    #1;
    e = enc1;
    chk("min_wait_addr", ca1, 1);
    chk("min_wait_rvalid", rv1, 0);
    tick();
    #1;
    chk("min_rvalid", rv1, 1);
    chk("min_rdata_core", rd1, e);
    chk("min_rdata", rd1, req_data[3*128 +: 128] ^ K);
    chk("min_rid", rid1, 3);
    // randomized traffic against a timeline model
    do_reset();
    ml = N - 1;
    mph = 0;
    mid = 0;
    md = '0;
    mf = '0;
    for (int c = 0; c < 800; c++) begin
      req_valid = 4'($urandom);
      for (int i = 0; i < N; i++) begin
        req_data[i*128 +: 128] = {$urandom, $urandom, $urandom, $urandom};
        req_flags[i*8 +: 8] = 8'($urandom);
      end
      resp_ready = ($urandom % 3) != 0;
      #1;
      if (mph == 0) begin
        g = rr(req_valid, ml);
        exp_rr = (g >= 0) ? 4'b1 << g : 4'b0;
        chk("rnd_ready", rr0, exp_rr);
        chk("rnd_idle_rvalid", rv0, 0);
        chk("rnd_idle_busy", b0, 0);
        if (g >= 0) begin
          mid = g;
          md = req_data[g*128 +: 128];
          mf = req_flags[g*8 +: 8];
          ml = g;
          mph = 1;
        end
      end else begin
        chk("rnd_busy_ready", rr0, 0);
        chk("rnd_busy", b0, 1);
        chk("rnd_addr", ca0, mph >= 2 && mph < LAT + 3);
        chk("rnd_flags", cf0, mph < LAT + 3 ? mf : 8'h0);
        chk("rnd_rvalid", rv0, mph >= LAT + 3);
        if (mph >= LAT + 3) begin
          chk("rnd_rdata", rd0, md ^ K);
          chk("rnd_rid", rid0, mid);
          mph = resp_ready ? 0 : mph + 1;
        end else mph++;
      end
      tick();
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
